// File: rtl/serdes_checker.sv
// serdes_checker: aligns a deserialized word stream against the transmitter's reference
// words by pulsing BITSLIP, then locks and counts matches and mismatches.
module serdes_checker #(
  parameter int WIDTH     = 8,
  parameter int TAPS      = 8,
  parameter int LOCK_CNT  = 16,
  parameter int SLIP_WAIT = 4,
  parameter int CNT_W     = 16,
  localparam int TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             I_STB,
  input  logic [WIDTH-1:0] I_DAT,
  input  logic             S_STB,
  input  logic [WIDTH-1:0] S_DAT,
  output logic             BITSLIP,
  output logic             O_LOCKED,
  output logic             O_ERROR,
  output logic [TAP_W-1:0] O_TAP,
  output logic [CNT_W-1:0] O_MATCH_CNT,
  output logic [CNT_W-1:0] O_ERR_CNT
);

  localparam int SW = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;
  localparam int VW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [SW-1:0]    SLIP_LOAD = SW'(SLIP_WAIT);
  localparam logic [VW-1:0]    VER_LOCK  = VW'(LOCK_CNT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [WIDTH-1:0] hist_r [TAPS];
  logic [TAPS-1:0]  hval_r;
  state_t           state_r, state_s;
  logic [SW-1:0]    slip_r, slip_s;
  logic [VW-1:0]    ver_r, ver_s;
  logic [TAP_W-1:0] tap_r, tap_s;
  logic [TAPS-1:0]  hit_s;
  logic [TAP_W-1:0] first_hit_s;
  logic             any_hit_s, tap_hit_s;
  logic             bitslip_s, error_s, clr_cnt_s, inc_match_s, inc_err_s;
  logic [CNT_W-1:0] match_cnt_r, err_cnt_r;
  logic             bitslip_r, locked_r, error_r;
  logic [TAP_W-1:0] o_tap_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1'b1);
  endfunction

  // Compare the received word against every usable tap of the pre-shift history
  always_comb begin
    hit_s = {TAPS{1'b0}};
    for (int k = 0; k < TAPS; k++) begin
      hit_s[k] = hval_r[k] && (hist_r[k] == S_DAT);
    end
  end

  // Lowest-index matching tap wins
  always_comb begin
    first_hit_s = {TAP_W{1'b0}};
    for (int k = TAPS - 1; k >= 0; k--) begin
      first_hit_s = hit_s[k] ? TAP_W'(k) : first_hit_s;
    end
  end

  assign any_hit_s = |hit_s;
  assign tap_hit_s = hit_s[tap_r];

  // Alignment FSM next-state and per-strobe actions
  always_comb begin
    state_s     = state_r;
    slip_s      = slip_r;
    ver_s       = ver_r;
    tap_s       = tap_r;
    bitslip_s   = 1'b0;
    error_s     = 1'b0;
    clr_cnt_s   = 1'b0;
    inc_match_s = 1'b0;
    inc_err_s   = 1'b0;
    if (S_STB) begin
      case (state_r)
        SEARCH: begin
          if (slip_r != {SW{1'b0}}) begin
            slip_s = slip_r - SW'(1'b1);
          end else if (bitslip_r) begin
            // keeps BITSLIP from firing on back-to-back cycles when SLIP_WAIT is 0
            slip_s = slip_r;
          end else if (any_hit_s) begin
            tap_s   = first_hit_s;
            ver_s   = VW'(1'b1);
            state_s = VERIFY;
          end else begin
            bitslip_s = 1'b1;
            slip_s    = SLIP_LOAD;
          end
        end
        VERIFY: begin
          if (tap_hit_s) begin
            if (ver_r == VER_LOCK) begin
              state_s   = LOCKED;
              clr_cnt_s = 1'b1;
            end else begin
              ver_s = ver_r + VW'(1'b1);
            end
          end else begin
            state_s   = SEARCH;
            bitslip_s = 1'b1;
            slip_s    = SLIP_LOAD;
          end
        end
        LOCKED: begin
          if (tap_hit_s) begin
            inc_match_s = 1'b1;
          end else begin
            inc_err_s = 1'b1;
            error_s   = 1'b1;
          end
        end
        default: begin
          state_s = SEARCH;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Reference history shift register with per-tap valid bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < TAPS; k++) begin
        hist_r[k] <= {WIDTH{1'b0}};
        hval_r[k] <= 1'b0;
      end
    end else if (I_STB) begin
      hist_r[0] <= I_DAT;
      hval_r[0] <= 1'b1;
      for (int k = 1; k < TAPS; k++) begin
        hist_r[k] <= hist_r[k-1];
        hval_r[k] <= hval_r[k-1];
      end
    end
  end

  // FSM state, slip-wait, verify and tap registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= SEARCH;
      slip_r  <= {SW{1'b0}};
      ver_r   <= {VW{1'b0}};
      tap_r   <= {TAP_W{1'b0}};
    end else begin
      state_r <= state_s;
      slip_r  <= slip_s;
      ver_r   <= ver_s;
      tap_r   <= tap_s;
    end
  end

  // Saturating match/error counters, cleared on entry to LOCKED
  always_ff @(posedge CLK) begin
    if (RST || clr_cnt_s) begin
      match_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (inc_match_s) begin
        match_cnt_r <= sat_inc(match_cnt_r);
      end
      if (inc_err_s) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end
    end
  end

  // Registered status outputs; lock indication trails the state by one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      bitslip_r <= 1'b0;
      error_r   <= 1'b0;
      locked_r  <= 1'b0;
      o_tap_r   <= {TAP_W{1'b0}};
    end else begin
      bitslip_r <= bitslip_s;
      error_r   <= error_s;
      locked_r  <= (state_r == LOCKED);
      o_tap_r   <= tap_r;
    end
  end

  assign BITSLIP     = bitslip_r;
  assign O_ERROR     = error_r;
  assign O_LOCKED    = locked_r;
  assign O_TAP       = o_tap_r;
  assign O_MATCH_CNT = match_cnt_r;
  assign O_ERR_CNT   = err_cnt_r;

endmodule

// File: doc/serdes_checker.md
Name: serdes_checker

Overview:
- Consumer of the transmitter's parallel comparison stream (I_STB/I_DAT) and of the ISERDES deserialized word stream (S_STB/S_DAT).
- Keeps a short history of transmitted words and, in the search state, finds which history tap matches the received words.
- Pulses BITSLIP until word alignment is found, then verifies, locks, and counts matches and errors for on-board readout.

Parameters:
- WIDTH, 8, word width of I_DAT and S_DAT (2..8).
- TAPS, 8, depth of the reference history shift register; maximum tolerated latency, in words (1..16).
- LOCK_CNT, 16, consecutive matches required in VERIFY before entering LOCKED.
- SLIP_WAIT, 4, S_STB strobes ignored after each BITSLIP pulse while the ISERDES settles.
- CNT_W, 16, width of the match and error counters.

Ports:
- CLK  input  1  system clock, the same clock as the transmitter.
- RST  input  1  reset, synchronous, active-high.
- I_STB  input  1  reference word valid (transmitter O_STB).
- I_DAT  input  WIDTH  reference word (transmitter O_DAT).
- S_STB  input  1  deserialized word valid.
- S_DAT  input  WIDTH  deserialized word from the ISERDES.
- BITSLIP  output  1  one-cycle bitslip request to the ISERDES.
- O_LOCKED  output  1  high while in LOCKED.
- O_ERROR  output  1  one-cycle pulse on each mismatch while LOCKED.
- O_TAP  output  $clog2(TAPS)  selected history tap; valid when O_LOCKED=1.
- O_MATCH_CNT  output  CNT_W  matches counted in LOCKED, saturating.
- O_ERR_CNT  output  CNT_W  mismatches counted in LOCKED, saturating.

Behaviour:
- Reset (CLK edge with RST=1):
  - History cleared to 0 with all valid bits 0.
  - State=SEARCH, slip-wait counter=0, verify counter=0.
  - All outputs 0.
  - RST asserted in any state, mid-operation included, restarts from this condition on the next cycle.
- History:
  - On I_STB, tap0<=I_DAT and tap[k]<=tap[k-1]; the per-tap valid bits shift in the same way.
  - A tap is usable only when its valid bit is 1.
- Compare timing: all comparisons on an S_STB cycle use the history contents from before that cycle's shift. Simultaneous I_STB and S_STB are legal, and the shift takes effect afterwards.
- SEARCH state:
  - If the slip-wait counter is nonzero, S_STB only decrements it.
  - Otherwise, on S_STB, compare S_DAT against every valid tap.
  - If any tap matches, latch the lowest matching index into the tap register, set the verify counter to 1, and go to VERIFY.
  - If no tap matches, assert BITSLIP for exactly one cycle (the cycle after the S_STB) and load the slip-wait counter with SLIP_WAIT.
  - BITSLIP is never asserted on two consecutive cycles, and never while the slip-wait counter is nonzero.
- VERIFY state, on S_STB:
  - Match against the latched tap: verify counter +1. When it reaches LOCK_CNT, go to LOCKED and clear both O_MATCH_CNT and O_ERR_CNT.
  - Mismatch: return to SEARCH, assert one BITSLIP pulse, and load the slip-wait counter.
- LOCKED state, on S_STB:
  - Match: O_MATCH_CNT +1.
  - Mismatch: O_ERR_CNT +1, and O_ERROR pulses high for one cycle, registered, 1 cycle after the S_STB.
  - The block stays LOCKED regardless of the error count; only RST leaves LOCKED.
- Counters: both saturate at 2^CNT_W-1 and never wrap.
- Output registers:
  - O_LOCKED and O_TAP are registered and follow the state one cycle later.
  - O_TAP holds its value while LOCKED.
- No S_STB: the state and counters hold indefinitely.
- I_STB absent with S_STB present: the stale history is compared as-is; the block does not filter this case.
- LOCK_CNT=1 is legal: the first match in SEARCH goes to VERIFY, and the next match locks.

Test Plan:
1. Reset hygiene: hold RST 5 cycles with both strobes toggling -> BITSLIP, O_LOCKED, O_ERROR, O_MATCH_CNT and O_ERR_CNT all 0 throughout and on the first cycle after release.
2. Aligned, latency 3: feed ROM words 0x00..0xFF and loop S_DAT back as I_DAT delayed by 3 strobes -> no BITSLIP; O_LOCKED=1 after LOCK_CNT+1=17 S_STBs; O_TAP=2; O_ERR_CNT=0; O_MATCH_CNT increments once per S_STB.
3. Bit misalignment, WIDTH=8: the bench model rotates S_DAT by 3 bits and each BITSLIP reduces the rotation by 1 -> exactly 3 BITSLIP pulses, each followed by 4 ignored strobes; then lock with O_TAP matching the programmed latency.
4. Injected errors while LOCKED: flip bit 0 on 5 chosen S_DAT words -> O_ERR_CNT=5, five one-cycle O_ERROR pulses, O_LOCKED remains 1.
5. Simultaneous strobes plus saturation, CNT_W=4: every S_STB coincident with I_STB; run 40 locked matches -> compare uses pre-shift history (no false errors) and O_MATCH_CNT stops at 15.
6. Mid-VERIFY failure, then reset mid-LOCKED: corrupt the 5th VERIFY word -> return to SEARCH with one BITSLIP. After lock, assert RST for 1 cycle -> O_LOCKED=0, counters 0, history invalid, and re-lock occurs with the same O_TAP.
